// File: rtl/vram_fill_engine_if.sv
// Bus bundle between the fill engine, the CPU write request and the VRAM write port.
interface vram_fill_engine_if #(
  parameter int P_AW = 13,
  parameter int P_CW = 3
);
  logic            iStart;
  logic [15:0]     iX0;
  logic [15:0]     iY0;
  logic [15:0]     iX1;
  logic [15:0]     iY1;
  logic [P_CW-1:0] iColor;
  logic            iCpuWe;
  logic [P_AW-1:0] iCpuAddr;
  logic [P_CW-1:0] iCpuData;
  logic            oVramWe;
  logic [P_AW-1:0] oVramAddr;
  logic [P_CW-1:0] oVramData;
  logic            oBusy;
  logic            oDone;

  // Requester side: launches fills, issues CPU writes, watches the VRAM port.
  modport master (
    output iStart, iX0, iY0, iX1, iY1, iColor, iCpuWe, iCpuAddr, iCpuData,
    input  oVramWe, oVramAddr, oVramData, oBusy, oDone
  );

  // Engine side.
  modport slave (
    input  iStart, iX0, iY0, iX1, iY1, iColor, iCpuWe, iCpuAddr, iCpuData,
    output oVramWe, oVramAddr, oVramData, oBusy, oDone
  );
endinterface

// File: rtl/vram_fill_engine.sv
// Rectangle fill engine: writes one color over an inclusive, clipped rectangle,
// one pixel per clock, sharing the VRAM write port with CPU writes (CPU wins).
module vram_fill_engine #(
  parameter int P_W  = 80,
  parameter int P_H  = 60,
  parameter int P_AW = 13,
  parameter int P_CW = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  vram_fill_engine_if.slave   bus
);

  localparam logic [15:0] X_MAX = 16'(P_W - 1);
  localparam logic [15:0] Y_MAX = 16'(P_H - 1);
  localparam logic [15:0] ROW_W = 16'(P_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q,   state_d;
  logic [15:0]     x_q,       x_d;
  logic [15:0]     y_q,       y_d;
  logic [15:0]     xs_q,      xs_d;
  logic [15:0]     x1c_q,     x1c_d;
  logic [15:0]     y1c_q,     y1c_d;
  logic [15:0]     rowbase_q, rowbase_d;
  logic [P_CW-1:0] color_q,   color_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;

  logic [15:0] x1c_in;
  logic [15:0] y1c_in;
  logic        rect_empty;
  logic        cpu_we;
  logic        last_pix;

  // The CPU path is combinational; it is also forced quiet while reset is held
  // so the port shows its reset values immediately.
  assign cpu_we = bus.iCpuWe & Reset;

  // Start-time clipping of the far corner against the screen edges.
  always_comb begin
    x1c_in     = (bus.iX1 > X_MAX) ? X_MAX : bus.iX1;
    y1c_in     = (bus.iY1 > Y_MAX) ? Y_MAX : bus.iY1;
    rect_empty = (bus.iX0 > x1c_in) || (bus.iY0 > y1c_in);
    last_pix   = (x_q == x1c_q) && (y_q == y1c_q);
  end

  // Next-state logic: start acceptance, row-major traversal with CPU stalls.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    xs_d      = xs_q;
    x1c_d     = x1c_q;
    y1c_d     = y1c_q;
    rowbase_d = rowbase_q;
    color_d   = color_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          busy_d = 1'b1;
          if (rect_empty) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FILL;
            x_d       = bus.iX0;
            y_d       = bus.iY0;
            xs_d      = bus.iX0;
            x1c_d     = x1c_in;
            y1c_d     = y1c_in;
            color_d   = bus.iColor;
            // Only multiply in the design; y0 is on-screen here so 16 bits suffice.
            rowbase_d = bus.iY0 * ROW_W;
          end
        end
      end
      ST_FILL: begin
        // A CPU write this cycle steals the port: hold everything.
        if (!cpu_we) begin
          if (last_pix) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (x_q < x1c_q) begin
            x_d = x_q + 16'd1;
          end else begin
            x_d       = xs_q;
            y_d       = y_q + 16'd1;
            rowbase_d = rowbase_q + ROW_W;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      xs_q      <= '0;
      x1c_q     <= '0;
      y1c_q     <= '0;
      rowbase_q <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xs_q      <= xs_d;
      x1c_q     <= x1c_d;
      y1c_q     <= y1c_d;
      rowbase_q <= rowbase_d;
      color_q   <= color_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Port arbitration: CPU first, then the engine's current pixel, else idle zeros.
  always_comb begin
    bus.oVramWe   = 1'b0;
    bus.oVramAddr = '0;
    bus.oVramData = '0;
    if (cpu_we) begin
      bus.oVramWe   = 1'b1;
      bus.oVramAddr = bus.iCpuAddr;
      bus.oVramData = bus.iCpuData;
    end else if (state_q == ST_FILL) begin
      bus.oVramWe   = 1'b1;
      bus.oVramAddr = P_AW'(rowbase_q + x_q);
      bus.oVramData = color_q;
    end
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Directed bench for vram_fill_engine: fills, clipping, CPU contention, restart, reset.
module tb_vram_fill_engine;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [12:0] wr_addr[$];
  logic [2:0]  wr_data[$];
  int          done_cyc;
  int          cpu_ok;
  int          busy_err;

  vram_fill_engine_if #(.P_AW(13), .P_CW(3)) bus ();

  vram_fill_engine #(.P_W(80), .P_H(60), .P_AW(13), .P_CW(3)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch a fill in the current cycle (edge T samples it) and record every
  // engine write from T+1 until oDone or the cycle limit. CPU writes to 4000
  // are injected at relative cycles stall_a/stall_b; a stray start at restart_c.
  task automatic run_fill(input logic [15:0] x0, input logic [15:0] y0,
                          input logic [15:0] x1, input logic [15:0] y1,
                          input logic [2:0] col, input int stall_a,
                          input int stall_b, input int restart_c, input int limit);
    wr_addr.delete();
    wr_data.delete();
    done_cyc = -1;
    cpu_ok   = 0;
    busy_err = 0;
    bus.iStart = 1'b1;
    bus.iX0 = x0; bus.iY0 = y0; bus.iX1 = x1; bus.iY1 = y1;
    bus.iColor = col;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    bus.iX0 = 16'd40; bus.iY0 = 16'd40; bus.iX1 = 16'd41; bus.iY1 = 16'd41;
    bus.iColor = 3'd7;
    for (int c = 1; c <= limit; c++) begin
      bus.iCpuWe   = (c == stall_a) || (c == stall_b);
      bus.iCpuAddr = 13'd4000;
      bus.iCpuData = 3'd5;
      if (c == restart_c) begin
        bus.iStart = 1'b1;
        bus.iX0 = 16'd50; bus.iY0 = 16'd50; bus.iX1 = 16'd60; bus.iY1 = 16'd55;
      end else begin
        bus.iStart = 1'b0;
      end
      #1;
      if (!bus.oBusy) busy_err++;
      if (bus.iCpuWe) begin
        if (bus.oVramWe && bus.oVramAddr == 13'd4000 && bus.oVramData == 3'd5) cpu_ok++;
      end else if (bus.oVramWe) begin
        wr_addr.push_back(bus.oVramAddr);
        wr_data.push_back(bus.oVramData);
      end
      if (bus.oDone) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.iCpuWe = 1'b0;
    bus.iStart = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic int qaddr(input int i);
    if (i < wr_addr.size()) return int'(wr_addr[i]);
    return -1;
  endfunction

  initial begin
    int errs;
    int derrs;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.iStart = 1'b0;
    bus.iX0 = '0; bus.iY0 = '0; bus.iX1 = '0; bus.iY1 = '0;
    bus.iColor = '0;
    bus.iCpuWe = 1'b0; bus.iCpuAddr = '0; bus.iCpuData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   int'(bus.oVramWe),   0);
    chk("rst_addr", int'(bus.oVramAddr), 0);
    chk("rst_data", int'(bus.oVramData), 0);
    chk("rst_busy", int'(bus.oBusy),     0);
    chk("rst_done", int'(bus.oDone),     0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full screen
    run_fill(16'd0, 16'd0, 16'd79, 16'd59, 3'b011, 0, 0, 0, 6000);
    chk("full_count", wr_addr.size(), 4800);
    errs = 0; derrs = 0;
    foreach (wr_addr[i]) begin
      if (int'(wr_addr[i]) != i) errs++;
      if (wr_data[i] != 3'b011) derrs++;
    end
    chk("full_order_errs", errs, 0);
    chk("full_data_errs", derrs, 0);
    chk("full_done", done_cyc, 4801);
    chk("full_busy_errs", busy_err, 0);
    chk("idle_after_busy", int'(bus.oBusy), 0);

    // Single pixel
    run_fill(16'd5, 16'd7, 16'd5, 16'd7, 3'b110, 0, 0, 0, 20);
    chk("single_count", wr_addr.size(), 1);
    chk("single_addr", qaddr(0), 565);
    chk("single_data", (wr_data.size() > 0) ? int'(wr_data[0]) : -1, 6);
    chk("single_done", done_cyc, 2);

    // Empty rectangle
    run_fill(16'd10, 16'd3, 16'd9, 16'd3, 3'b001, 0, 0, 0, 20);
    chk("empty_count", wr_addr.size(), 0);
    chk("empty_done", done_cyc, 1);
    chk("empty_busy_errs", busy_err, 0);

    // Clipping
    run_fill(16'd78, 16'd58, 16'd200, 16'd100, 3'b010, 0, 0, 0, 20);
    chk("clip_count", wr_addr.size(), 4);
    chk("clip_a0", qaddr(0), 4718);
    chk("clip_a1", qaddr(1), 4719);
    chk("clip_a2", qaddr(2), 4798);
    chk("clip_a3", qaddr(3), 4799);
    chk("clip_done", done_cyc, 5);

    // CPU contention at T+2, T+3
    run_fill(16'd22, 16'd0, 16'd24, 16'd1, 3'b100, 2, 3, 0, 30);
    chk("cpu_slots", cpu_ok, 2);
    chk("cont_count", wr_addr.size(), 6);
    chk("cont_a0", qaddr(0), 22);
    chk("cont_a1", qaddr(1), 23);
    chk("cont_a2", qaddr(2), 24);
    chk("cont_a3", qaddr(3), 102);
    chk("cont_a4", qaddr(4), 103);
    chk("cont_a5", qaddr(5), 104);
    chk("cont_done", done_cyc, 9);

    // Stray start mid-fill is dropped
    run_fill(16'd0, 16'd0, 16'd3, 16'd1, 3'b101, 0, 0, 3, 30);
    chk("restart_count", wr_addr.size(), 8);
    chk("restart_last", qaddr(7), 83);
    chk("restart_done", done_cyc, 9);
    chk("restart_idle", int'(bus.oBusy), 0);

    // Reset mid-fill
    bus.iStart = 1'b1;
    bus.iX0 = 16'd0; bus.iY0 = 16'd0; bus.iX1 = 16'd79; bus.iY1 = 16'd59;
    bus.iColor = 3'b011;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(bus.oBusy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.oBusy), 0);
    chk("mid_rst_we", int'(bus.oVramWe), 0);
    chk("mid_rst_addr", int'(bus.oVramAddr), 0);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.oVramWe || bus.oDone || bus.oBusy) errs++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.oVramWe || bus.oDone || bus.oBusy) errs++;
    end
    chk("post_rst_quiet", errs, 0);

    // Fresh fill after reset
    run_fill(16'd1, 16'd1, 16'd2, 16'd2, 3'b111, 0, 0, 0, 20);
    chk("after_count", wr_addr.size(), 4);
    chk("after_a0", qaddr(0), 81);
    chk("after_a1", qaddr(1), 82);
    chk("after_a2", qaddr(2), 161);
    chk("after_a3", qaddr(3), 162);
    chk("after_done", done_cyc, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_fill_engine.md
# vram_fill_engine

Hardware rectangle-fill engine that writes one color into every VRAM cell of an inclusive rectangle, one pixel per clock. It replaces the microcode `DRAW_SQR` software loop (`STC`/`INC`/`BLE`). It sits between the MiniAlu CPU and the VRAM write port and arbitrates that single port. CPU `STC` writes always win; the engine stalls while they occur.

## Interface
- `P_W`, 80: VRAM width in pixels; valid x range 0..P_W-1.
- `P_H`, 60: VRAM height in pixels; valid y range 0..P_H-1.
- `P_AW`, 13: VRAM address width; must satisfy P_W*P_H <= 2^P_AW.
- `P_CW`, 3: color width; matches `COLOR_*` encodings.

Ports:
- `Clock` in 1: system clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `iStart` in 1: one-cycle pulse that launches a fill; ignored while `oBusy`=1.
- `iX0` in 16: left x; `iY0` in 16: top y; `iX1` in 16: right x; `iY1` in 16: bottom y. All bounds inclusive.
- `iColor` in P_CW: fill color, latched at start.
- `iCpuWe` in 1: CPU VRAM write request (from `STC`).
- `iCpuAddr` in P_AW: CPU write address.
- `iCpuData` in P_CW: CPU write data.
- `oVramWe` out 1: VRAM write enable.
- `oVramAddr` out P_AW: VRAM write address.
- `oVramData` out P_CW: VRAM write data.
- `oBusy` out 1: high from the cycle after an accepted start until the cycle of `oDone`, inclusive.
- `oDone` out 1: one-cycle completion pulse.

## Operation
- Arithmetic is unsigned 16-bit, and all comparisons are unsigned.
- Clipping is applied at start:
  - `x1c = min(iX1, P_W-1)` and `y1c = min(iY1, P_H-1)`.
  - If `iX0 > x1c` or `iY0 > y1c`, the rectangle is empty.
- FSM states:
  - IDLE → FILL: on `iStart` with a non-empty rectangle. Latch `x=iX0`, `y=iY0`, `xs=iX0`, `x1c`, `y1c`, `iColor`, and `rowbase=iY0*P_W`.
  - IDLE → DONE: on `iStart` with an empty rectangle. No writes are issued.
  - FILL: each cycle with `iCpuWe`=0, issue a write of color at `rowbase+x`, then advance the coordinates:
    - If `x < x1c`, increment `x`.
    - Else set `x = xs`, increment `y`, and add P_W to `rowbase`.
    - When the write is for `(x1c, y1c)`, go to DONE.
  - FILL stall: each cycle with `iCpuWe`=1, the engine issues no write and holds all of its state.
  - DONE: assert `oDone` for one cycle, then go to IDLE.
- Traversal order is row-major: x fastest, y slowest.
- `rowbase` is kept incrementally. No multiplier is used in FILL; the start-time `iY0*P_W` may use a constant multiply.
- Output mux:
  - When `iCpuWe`=1, outputs = CPU address and data with `oVramWe`=1, in any state.
  - Else in FILL, outputs = engine pixel.
  - Else `oVramWe`=0, with address and data held at 0.
- Inputs other than `iStart`, `iCpuWe`, `iCpuAddr` and `iCpuData` are sampled only on the accepted start cycle. Later changes have no effect.

## Timing
- Reset values: state = IDLE; `oVramWe`=0, `oVramAddr`=0, `oVramData`=0, `oBusy`=0, `oDone`=0; all internal registers 0.
- The CPU path is combinational: a CPU write appears on the VRAM port in the same cycle as `iCpuWe`.
- Engine writes are registered. If `iStart` is sampled at edge T, the first pixel write is in cycle T+1.
- With no stalls, a rectangle of N = (x1c-x0+1)(y1c-y0+1) pixels writes in cycles T+1..T+N, and `oDone`=1 in cycle T+N+1.
- Each CPU stall cycle delays every later event by one cycle.
- Empty rectangle: `oDone`=1 in cycle T+1. `oBusy` is also high in that single cycle; no writes occur.
- `iStart` while busy or in DONE is dropped, not queued.
- A simultaneous `iStart` and `iCpuWe` in IDLE: start is accepted and the CPU write proceeds normally.
- Reset asserted mid-fill: outputs drop to reset values asynchronously. No further engine writes occur, and there is no `oDone`.

## Test plan
- Full-screen fill: start with (0,0)-(79,59), color 3'b011, no CPU traffic.
  - Required: exactly 4800 writes, addresses 0..4799 in order, all data 3'b011.
  - `oDone` at T+4801.
- Single pixel and empty:
  - (5,7)-(5,7): one write at addr 565, then `oDone` at T+2.
  - (10,3)-(9,3): zero writes, `oDone` at T+1.
- Clipping: start with (78,58)-(200,100).
  - Required: writes at exactly 4718, 4719, 4798, 4799.
  - `oDone` at T+5.
- CPU contention: fill (22,0)-(24,1), with `iCpuWe`=1 at addr 4000 during cycles T+2 and T+3.
  - Required: cycles T+2 and T+3 show addr 4000; engine addresses 22, 23, 24, 102, 103, 104 appear with none skipped or repeated.
  - `oDone` at T+9.
- Restart and reset:
  - `iStart` pulsed mid-fill is ignored; the pixel count is unchanged.
  - `Reset` low during a fill clears `oBusy` and `oVramWe` immediately.
  - After reset release, a new start fills correctly from its own origin.
